// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares the byte-wide, single-port instruction memory between the fetch unit
// (32-bit little-endian reads, issued as four byte reads) and the boot loader
// (single byte writes). Round-robin arbitration happens only while idle.
// Build macro IMEM_MISALIGN_TRAP_EN: when defined, a fetch whose address is not
// word aligned touches no memory and returns f_err one cycle after acceptance.

module imem_port_arbiter #(
    parameter int ADDR_W     = 20,
    parameter bit LOADER_1ST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_ready,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [7:0]        l_wdata,
    output logic              l_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              ptr_reg, ptr_next;       // 1 = loader wins next contention
    logic [1:0]        cnt_reg, cnt_next;       // byte index strobed this cycle
    logic              mem_en_reg, mem_en_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [7:0]        mem_wdata_reg, mem_wdata_next;
    logic              rd_pend_reg;             // mem_rdata carries a fetch byte now
    logic [1:0]        rd_idx_reg;              // which byte of the word it is
    logic              f_rvalid_reg;
    logic [31:0]       f_rdata_reg;
    logic [23:0]       lane_bytes;              // bytes 0..2 of the word in flight
    logic              idle;
    logic              trap_hit;
    logic              unused_addr_bits;

    assign idle    = (state_reg == IDLE);
    assign f_ready = idle & f_req & (~l_req | ~ptr_reg);
    assign l_ack   = idle & l_req & (~f_req | ptr_reg);

    // Upper fetch address bits lie outside the memory and are ignored.
    assign unused_addr_bits = ^f_addr[31:ADDR_W];

`ifdef IMEM_MISALIGN_TRAP_EN
    assign trap_hit = f_ready & (f_addr[1:0] != 2'b00);
`else
    assign trap_hit = 1'b0;
`endif

    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign f_rvalid  = f_rvalid_reg;
    assign f_rdata   = f_rdata_reg;

    // State, round-robin pointer and byte counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            ptr_reg   <= LOADER_1ST;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: grant in IDLE, walk four bytes in READ, one cycle in WRITE
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (l_ack) begin
                    state_next = WRITE;
                end else if (f_ready && !trap_hit) begin
                    state_next = READ;
                    cnt_next   = 2'd0;
                end
                // Under contention somebody is always granted; hand priority over.
                if (f_req && l_req) begin
                    ptr_next = ~ptr_reg;
                end
            end
            READ: begin
                if (cnt_reg == 2'd3) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered memory strobes
    always_comb begin
        mem_en_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (l_ack) begin
                    mem_en_next    = 1'b1;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = l_addr;
                    mem_wdata_next = l_wdata;
                end else if (f_ready && !trap_hit) begin
                    mem_en_next   = 1'b1;
                    mem_addr_next = f_addr[ADDR_W-1:0];
                end
            end
            READ: begin
                // Address simply wraps at the top of memory.
                if (cnt_reg != 2'd3) begin
                    mem_en_next   = 1'b1;
                    mem_addr_next = mem_addr_reg + ADDR_W'(1);
                end
            end
            default: begin
                mem_en_next = 1'b0;
            end
        endcase
    end

    // Memory strobe output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 8'h00;
        end else begin
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    // Track which byte the memory returns, one cycle behind its read strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_pend_reg <= 1'b0;
            rd_idx_reg  <= 2'd0;
        end else begin
            rd_pend_reg <= mem_en_reg & ~mem_we_reg;
            rd_idx_reg  <= cnt_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            // Capture byte gi of the word being fetched
            always_ff @(posedge clk) begin
                if (!rst) begin
                    lane_reg <= 8'h00;
                end else if (rd_pend_reg && (rd_idx_reg == 2'(gi))) begin
                    lane_reg <= mem_rdata;
                end
            end
            assign lane_bytes[gi*8 +: 8] = lane_reg;
        end
    endgenerate

`ifdef IMEM_MISALIGN_TRAP_EN
    logic trap_reg;
    logic f_err_reg;

    // Remember a trapped fetch so its error response goes out one cycle later
    always_ff @(posedge clk) begin
        if (!rst) begin
            trap_reg <= 1'b0;
        end else begin
            trap_reg <= trap_hit;
        end
    end

    assign f_err = f_err_reg;
`else
    assign f_err = 1'b0;
`endif

    // Assemble the word when byte 3 arrives and emit a one-cycle response
    always_ff @(posedge clk) begin
        if (!rst) begin
            f_rvalid_reg <= 1'b0;
            f_rdata_reg  <= 32'h0;
`ifdef IMEM_MISALIGN_TRAP_EN
            f_err_reg    <= 1'b0;
`endif
        end else begin
            f_rvalid_reg <= 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
            f_err_reg    <= 1'b0;
`endif
            if (rd_pend_reg && (rd_idx_reg == 2'd3)) begin
                f_rvalid_reg <= 1'b1;
                f_rdata_reg  <= {mem_rdata, lane_bytes};
            end
`ifdef IMEM_MISALIGN_TRAP_EN
            if (trap_reg) begin
                f_rvalid_reg <= 1'b1;
                f_err_reg    <= 1'b1;
                f_rdata_reg  <= 32'h0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: byte memory model, scoreboard of expected fetch
// responses, table of fetch vectors and hand-written multi-cycle sequences.
// Honours IMEM_MISALIGN_TRAP_EN when computing misaligned-fetch expectations.

module tb_imem_port_arbiter;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              f_req = 1'b0;
    logic [31:0]       f_addr = 32'h0;
    logic              f_ready;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              f_err;
    logic              l_req = 1'b0;
    logic [ADDR_W-1:0] l_addr = '0;
    logic [7:0]        l_wdata = 8'h00;
    logic              l_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    imem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .LOADER_1ST (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_ready   (f_ready),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .l_req     (l_req),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_ack     (l_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory: registered read, data valid the cycle after the strobe
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    initial begin
        mem_rdata = 8'h00;
        mem[20'h00100] = 8'h13; mem[20'h00101] = 8'h00;
        mem[20'h00102] = 8'h00; mem[20'h00103] = 8'h93;
        mem[20'h00104] = 8'h55; mem[20'h00105] = 8'h66;
        for (int i = 0; i < 8; i++) mem[20'h00200 + i] = 8'(i + 1);
        mem[20'hFFFFE] = 8'hEE; mem[20'hFFFFF] = 8'hFF;
        mem[20'h00000] = 8'h11; mem[20'h00001] = 8'h22;
        forever begin
            @(posedge clk);
            if (mem_en === 1'b1) begin
                if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
                else                 mem_rdata <= mem[mem_addr];
            end
        end
    end

    typedef struct {
        logic [31:0] word;
        logic        err;
        int          acc;   // cycle count just after the accept edge
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;  // expected word when the fetch proceeds byte-wise
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon_step();
        exp_t e;
        if (f_rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_rvalid: got rvalid=1 data=0x%h, want no response (cycle %0d)", f_rdata, cyc);
            end else begin
                e = sb.pop_front();
                $display("fetch response: data=0x%h err=%b latency=%0d", f_rdata, f_err, cyc - e.acc);
                check("rdata", f_rdata, e.word);
                check("err", 32'(f_err), 32'(e.err));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] w);
        logic              trap;
        logic              got;
        logic [ADDR_W-1:0] base;
        trap = 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
        trap = (a[1:0] != 2'b00);
`endif
        f_req  = 1'b1;
        f_addr = a;
        got    = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = f_ready;
        end
        check("f_ready", 32'(got), 32'd1);
        if (!got) begin
            f_req = 1'b0;
            @(posedge clk); #1;
            return;
        end
        sb.push_back('{word: (trap ? 32'h0 : w), err: trap, acc: cyc + 1, lat: (trap ? 1 : 5)});
        @(posedge clk); #1;
        f_req = 1'b0;
        base  = a[ADDR_W-1:0];
        if (trap) begin
            @(negedge clk);
            check("trap_no_mem_en", 32'(mem_en), 32'd0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("rd_strobe", 32'({mem_en, mem_we, mem_addr}),
                      32'({1'b1, 1'b0, base + ADDR_W'(k)}));
            end
        end
        drain();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        logic got;
        l_req   = 1'b1;
        l_addr  = a;
        l_wdata = d;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = l_ack;
        end
        check("l_ack", 32'(got), 32'd1);
        @(posedge clk); #1;
        l_req = 1'b0;
        if (!got) return;
        @(negedge clk);
        $display("loader write: addr=0x%h data=0x%h", a, d);
        check("wr_strobe", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, a, d}));
        @(negedge clk);
        check("wr_done", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c1, c2, ng;
        logic       got;
        logic [3:0] seq;

        vecs[0] = '{addr: 32'h0000_0100, word: 32'h9300_0013};
        vecs[1] = '{addr: 32'hABC0_0100, word: 32'h9300_0013};
        vecs[2] = '{addr: 32'h0000_0200, word: 32'h0403_0201};
        vecs[3] = '{addr: 32'h0000_0204, word: 32'h0807_0605};
        vecs[4] = '{addr: 32'h000F_FFFE, word: 32'h2211_FFEE};
        vecs[5] = '{addr: 32'h0000_0102, word: 32'h6655_9300};

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        check("rst_f_rdata", f_rdata, 32'd0);
        check("rst_f_err", 32'(f_err), 32'd0);
        check("rst_mem_en_we", 32'({mem_en, mem_we}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_grants", 32'({f_ready, l_ack}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Table of fetch vectors
        for (int v = 0; v < 6; v++) do_fetch(vecs[v].addr, vecs[v].word);

        // Write then read
        do_write(20'h00010, 8'hAA);
        do_write(20'h00011, 8'hBB);
        do_write(20'h00012, 8'hCC);
        do_write(20'h00013, 8'hDD);
        do_fetch(32'h0000_0010, 32'hDDCC_BBAA);

        // Gapless fetch: request held across two words
        f_req  = 1'b1;
        f_addr = 32'h0000_0200;
        got = 1'b0;
        c1  = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = f_ready; end
        check("gap_first_ready", 32'(got), 32'd1);
        c1 = cyc;
        sb.push_back('{word: 32'h0403_0201, err: 1'b0, acc: cyc + 1, lat: 5});
        @(posedge clk); #1;
        f_addr = 32'h0000_0204;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = f_ready; end
        check("gap_second_ready", 32'(got), 32'd1);
        c2 = cyc;
        sb.push_back('{word: 32'h0807_0605, err: 1'b0, acc: cyc + 1, lat: 5});
        check("gap_accept_spacing", 32'(c2 - c1), 32'd5);
        @(posedge clk); #1;
        f_req = 1'b0;
        drain();

        // Contention from reset: loader first, then alternating
        rst     = 1'b0;
        f_req   = 1'b1;
        f_addr  = 32'h0000_0200;
        l_req   = 1'b1;
        l_addr  = 20'h00300;
        l_wdata = 8'h5A;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ng  = 0;
        seq = 4'b0000;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(negedge clk);
            check("one_grant", 32'(f_ready & l_ack), 32'd0);
            if (l_ack) begin
                seq[ng] = 1'b1;
                ng++;
            end else if (f_ready) begin
                seq[ng] = 1'b0;
                ng++;
                sb.push_back('{word: 32'h0403_0201, err: 1'b0, acc: cyc + 1, lat: 5});
            end
        end
        check("contention_grants", 32'(ng), 32'd4);
        check("contention_order", 32'(seq), 32'b0101);
        @(posedge clk); #1;
        f_req = 1'b0;
        l_req = 1'b0;
        drain();

        // Reset in cycle 2 of a read abandons it
        f_req  = 1'b1;
        f_addr = 32'h0000_0100;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = f_ready; end
        check("mid_rst_ready", 32'(got), 32'd1);
        @(posedge clk); #1;          // edge 0
        f_req = 1'b0;
        @(posedge clk);              // edge 1
        @(posedge clk); #1;          // edge 2
        rst = 1'b0;
        @(posedge clk); #1;          // edge 3 samples reset
        rst    = 1'b1;
        f_req  = 1'b1;
        f_addr = 32'h0000_0200;
        @(negedge clk);
        check("mid_rst_mem_en", 32'(mem_en), 32'd0);
        check("mid_rst_idle", 32'(f_ready), 32'd1);
        f_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mid_rst_no_rvalid", 32'(f_rvalid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
